// File: rtl/inst_mem_loader.sv
// Byte-addressed instruction memory with a streaming byte loader
// and a registered little-endian word fetch port.
module inst_mem_loader #(
  parameter int XLEN = 32,
  parameter int DEPTH = 1024,
  parameter logic [XLEN-1:0] NOP = 32'h0000_0013,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_start,
  input  logic [AW-1:0]   ld_base,
  input  logic [AW:0]     ld_len,
  input  logic            ld_valid,
  input  logic [7:0]      ld_data,
  output logic            ld_ready,
  output logic            ld_busy,
  output logic            ld_done,
  output logic            ld_err,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [1:0]      if_fault
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW:0]     len_q, len_d;
  logic            err_q, err_d;
  logic            wr_en;
  logic [AW:0]     cnt_inc;

  logic [7:0]      mem_q [DEPTH];

  logic            fire;
  logic            mis;
  logic            oor;
  logic [AW-1:0]   rd_idx;
  logic [XLEN-1:0] rd_word;
  logic            if_valid_q;
  logic [XLEN-1:0] if_inst_q;
  logic [1:0]      if_fault_q;

  assign cnt_inc = cnt_q + (AW+1)'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          ptr_d   = ld_base;
          cnt_d   = '0;
          len_d   = ld_len;
          err_d   = 1'b0;
          state_d = (ld_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_inc;
          // top byte ends the session; no wrap
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
          end else if (ptr_q == AW'(DEPTH-1)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[ptr_q] <= ld_data;
    end
  end

  assign ld_ready = (state_q == S_LOAD);
  assign ld_busy  = (state_q != S_IDLE);
  assign ld_done  = (state_q == S_DONE);
  assign ld_err   = err_q;

  assign if_ready = (state_q == S_IDLE);
  assign fire     = if_req & if_ready;
  assign mis      = (if_addr % XLEN'(NB)) != '0;
  assign oor      = if_addr > XLEN'(DEPTH - NB);
  assign rd_idx   = if_addr[AW-1:0];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++) begin
      rd_word[8*i +: 8] = mem_q[rd_idx + AW'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid_q <= 1'b0;
      if_inst_q  <= NOP;
      if_fault_q <= 2'b00;
    end else begin
      if_valid_q <= fire;
      if (fire) begin
        if (mis) begin
          if_inst_q  <= NOP;
          if_fault_q <= 2'b01;
        end else if (oor) begin
          if_inst_q  <= NOP;
          if_fault_q <= 2'b10;
        end else begin
          if_inst_q  <= rd_word;
          if_fault_q <= 2'b00;
        end
      end
    end
  end

  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign if_fault = if_fault_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: fetch vector table, loader sequences
// and a queue scoreboard checked whenever if_valid is seen.
module tb_inst_mem_loader;

  localparam int XLEN = 32;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            ld_start;
  logic [AW-1:0]   ld_base;
  logic [AW:0]     ld_len;
  logic            ld_valid;
  logic [7:0]      ld_data;
  logic            ld_ready;
  logic            ld_busy;
  logic            ld_done;
  logic            ld_err;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_inst;
  logic [1:0]      if_fault;

  inst_mem_loader #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_err(ld_err),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_valid(if_valid),
    .if_inst(if_inst), .if_fault(if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [1:0]  fault;
  } vec_t;

  int nchk = 0;
  int nfail = 0;
  exp_t sbq[$];
  logic [7:0] mdl [DEPTH];
  logic [31:0] last_inst = NOP;
  exp_t mon_e;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_fetch(logic [31:0] a);
    exp_t e;
    if (a % 4 != 0) begin
      e.inst = NOP;
      e.fault = 2'b01;
    end else if (a > DEPTH - 4) begin
      e.inst = NOP;
      e.fault = 2'b10;
    end else begin
      e.inst = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
      e.fault = 2'b00;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_inst", if_inst, NOP);
      last_inst = NOP;
    end else if (if_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_if_valid", if_valid, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("if_inst", if_inst, mon_e.inst);
        chk("if_fault", if_fault, mon_e.fault);
        last_inst = mon_e.inst;
      end
    end else begin
      chk("if_inst_hold", if_inst, last_inst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(logic [31:0] a, exp_t e);
    if_req = 1'b1;
    if_addr = a;
    chk("if_ready", if_ready, 1);
    sbq.push_back(e);
    tick();
    if_req = 1'b0;
  endtask

  task automatic load(int base, int len, logic [63:0] d,
                      bit gap, bit wf, logic [31:0] fa);
    int nacc;
    bit experr;
    nacc = (len < DEPTH - base) ? len : DEPTH - base;
    experr = (len > DEPTH - base);
    ld_start = 1'b1;
    ld_base = AW'(base);
    ld_len = (AW+1)'(len);
    if (wf) begin
      if_req = 1'b1;
      if_addr = fa;
      sbq.push_back(model_fetch(fa));
    end
    tick();
    ld_start = 1'b0;
    if_req = 1'b0;
    chk("ld_busy_start", ld_busy, 1);
    chk("if_ready_busy", if_ready, 0);
    chk("ld_err_cleared", ld_err, 0);
    chk("ld_ready_start", ld_ready, nacc != 0);
    for (int i = 0; i < nacc; i++) begin
      if (gap && (i % 2 == 1)) begin
        ld_valid = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h0;
        tick();
        if_req = 1'b0;
      end
      ld_valid = 1'b1;
      ld_data = d[8*i +: 8];
      chk("ld_ready", ld_ready, 1);
      tick();
      mdl[base+i] = d[8*i +: 8];
    end
    ld_valid = 1'b0;
    chk("ld_done", ld_done, 1);
    chk("ld_err", ld_err, experr);
    chk("ld_ready_done", ld_ready, 0);
    tick();
    chk("ld_done_pulse", ld_done, 0);
    chk("ld_busy_idle", ld_busy, 0);
    chk("if_ready_idle", if_ready, 1);
    chk("ld_err_sticky", ld_err, experr);
  endtask

  task automatic chk_reset_outs();
    chk("r_ld_ready", ld_ready, 0);
    chk("r_ld_busy", ld_busy, 0);
    chk("r_ld_done", ld_done, 0);
    chk("r_ld_err", ld_err, 0);
    chk("r_if_valid", if_valid, 0);
    chk("r_if_inst", if_inst, NOP);
    chk("r_if_fault", if_fault, 0);
    chk("r_if_ready", if_ready, 1);
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{32'd0,          32'h0000_0013, 2'b00};
    vt[1] = '{32'd4,          32'h0010_0093, 2'b00};
    vt[2] = '{32'd2,          NOP,           2'b01};
    vt[3] = '{32'd1024,       NOP,           2'b10};
    vt[4] = '{32'd1023,       NOP,           2'b01};
    vt[5] = '{32'd1020,       32'h2211_A55A, 2'b00};
    vt[6] = '{32'h8000_0000,  NOP,           2'b10};
    vt[7] = '{32'd1028,       NOP,           2'b10};
    vt[8] = '{32'd6,          NOP,           2'b01};

    rst = 1'b1;
    ld_start = 1'b0;
    ld_base = '0;
    ld_len = '0;
    ld_valid = 1'b0;
    ld_data = '0;
    if_req = 1'b0;
    if_addr = '0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    rst = 1'b1;
    tick();

    load(0, 8, 64'h0010_0093_0000_0013, 1'b1, 1'b0, 0);
    load(1020, 2, 64'h0000_A55A, 1'b0, 1'b0, 0);
    load(1022, 4, 64'h4433_2211, 1'b0, 1'b0, 0);

    for (int i = 0; i < 9; i++) begin
      fetch(vt[i].addr, '{vt[i].inst, vt[i].fault});
    end
    tick();
    tick();

    load(0, 4, 64'h0000_0537, 1'b0, 1'b1, 32'd0);
    fetch(32'd0, model_fetch(32'd0));
    load(8, 4, 64'hDEAD_BEEF, 1'b1, 1'b0, 0);
    load(8, 0, 64'h0, 1'b0, 1'b0, 0);
    fetch(32'd8, model_fetch(32'd8));
    fetch(32'd4, model_fetch(32'd4));
    tick();

    load(16, 4, 64'hDDCC_BBAA, 1'b0, 1'b0, 0);
    ld_start = 1'b1;
    ld_base = AW'(16);
    ld_len = (AW+1)'(8);
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data = 8'(8'h11 * (i + 1));
      tick();
      mdl[16+i] = 8'(8'h11 * (i + 1));
    end
    ld_data = 8'h44;
    rst = 1'b0;
    #2;
    chk_reset_outs();
    tick();
    rst = 1'b1;
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_done", ld_done, 0);
      chk("t6_idle", ld_busy, 0);
      tick();
    end
    fetch(32'd16, model_fetch(32'd16));
    chk("t6_model", {mdl[19], mdl[18], mdl[17], mdl[16]},
        32'hDD33_2211);
    tick();
    tick();
    chk("sb_drain", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
